timer_setter: RTL and testbench

- Front-end controller that drives the HH:MM:SS countdown timer. It is the writer of that timer's min_ini, hour_ini, rst_state, en and setting inputs.
- Turns debounced push-button levels into an edited setting value, a one-cycle load pulse, and run/pause/done control.
- Sits between the debounce stage and the countdown counter. Also supplies BCD digits of the value being edited to the 7-segment mux.

---
 rtl/timer_setter_if.sv | 32 +++
 rtl/timer_setter.sv | 234 +++++++++++++++++++++++
 tb/tb_timer_setter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_setter_if.sv
// timer_setter_if: bundles the debounced button levels, the counter's zero flag and
// the setter's outputs toward the countdown counter and the 7-segment mux.
// master: the setter side. slave: the environment (buttons, counter, display).
interface timer_setter_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_start;
  logic       count_zero;
  logic [5:0] min_ini;
  logic [5:0] hour_ini;
  logic       rst_state;
  logic       en;
  logic       setting;
  logic       field_sel;
  logic [3:0] set_min0;
  logic [3:0] set_min1;
  logic [3:0] set_hour0;
  logic [3:0] set_hour1;

  modport master (
    input  btn_mode, btn_up, btn_down, btn_start, count_zero,
    output min_ini, hour_ini, rst_state, en, setting, field_sel,
    output set_min0, set_min1, set_hour0, set_hour1
  );

  modport slave (
    output btn_mode, btn_up, btn_down, btn_start, count_zero,
    input  min_ini, hour_ini, rst_state, en, setting, field_sel,
    input  set_min0, set_min1, set_hour0, set_hour1
  );
endinterface

// File: rtl/timer_setter.sv
// timer_setter: button-driven front end for the HH:MM:SS countdown timer.
// Edits the hour/minute setting, issues a one-cycle load strobe, and controls
// run/pause/done. Optional auto-repeat on held up/down: TIMER_SETTER_AUTOREPEAT_EN.
module timer_setter #(
  parameter int unsigned HOLD_CYCLES   = 50,
  parameter int unsigned REPEAT_CYCLES = 10
) (
  input logic             clk,
  input logic             rst_n,
  timer_setter_if.master  io_bus
);

  // Zero-length hold/repeat intervals make no sense; catch them at elaboration.
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("timer_setter: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {StSetMin, StSetHour, StRun, StPause, StDone} state_e;

  state_e     r_state, w_state_d;
  logic [5:0] r_min, w_min_d;
  logic [5:0] r_hour, w_hour_d;
  logic       r_rst_state, w_rst_state_d;
  logic       r_mode_prev, r_up_prev, r_down_prev, r_start_prev;

  logic w_mode_p, w_up_p, w_down_p, w_start_p;
  logic w_in_set, w_nonzero;
  logic w_rpt_up, w_rpt_dn;
  logic w_step_up, w_step_dn;

  assign w_mode_p  = io_bus.btn_mode  & ~r_mode_prev;
  assign w_up_p    = io_bus.btn_up    & ~r_up_prev;
  assign w_down_p  = io_bus.btn_down  & ~r_down_prev;
  assign w_start_p = io_bus.btn_start & ~r_start_prev;

  assign w_in_set  = (r_state == StSetMin) || (r_state == StSetHour);
  assign w_nonzero = (r_min != 6'd0) || (r_hour != 6'd0);

  // Simultaneous up+down presses cancel each other.
  assign w_step_up = (w_up_p & ~w_down_p) | w_rpt_up;
  assign w_step_dn = (w_down_p & ~w_up_p) | w_rpt_dn;

  // Button history; reset high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_prev  <= 1'b1;
      r_up_prev    <= 1'b1;
      r_down_prev  <= 1'b1;
      r_start_prev <= 1'b1;
    end else begin
      r_mode_prev  <= io_bus.btn_mode;
      r_up_prev    <= io_bus.btn_up;
      r_down_prev  <= io_bus.btn_down;
      r_start_prev <= io_bus.btn_start;
    end
  end

`ifdef TIMER_SETTER_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RepW  = $clog2(REPEAT_CYCLES + 1);

  logic             r_hold_act, w_hold_act_d;
  logic             r_hold_dn, w_hold_dn_d;
  logic             r_hold_rep, w_hold_rep_d;
  logic [HoldW-1:0] r_hold_cnt, w_hold_cnt_d;
  logic [RepW-1:0]  r_rep_cnt, w_rep_cnt_d;
  logic             w_held;

  // The tracked button is still the only one of up/down that is high.
  assign w_held = r_hold_dn ? (io_bus.btn_down & ~io_bus.btn_up)
                            : (io_bus.btn_up & ~io_bus.btn_down);

  // Hold tracking: press cycle counts as held cycle 1; first repeat at HOLD_CYCLES.
  always_comb begin
    w_hold_act_d = r_hold_act;
    w_hold_dn_d  = r_hold_dn;
    w_hold_rep_d = r_hold_rep;
    w_hold_cnt_d = r_hold_cnt;
    w_rep_cnt_d  = r_rep_cnt;
    w_rpt_up     = 1'b0;
    w_rpt_dn     = 1'b0;
    if (!w_in_set || w_start_p || w_mode_p) begin
      w_hold_act_d = 1'b0;
    end else if (w_up_p ^ w_down_p) begin
      w_hold_act_d = 1'b1;
      w_hold_dn_d  = w_down_p;
      w_hold_rep_d = 1'b0;
      w_hold_cnt_d = HoldW'(1);
      w_rep_cnt_d  = '0;
    end else if (w_up_p & w_down_p) begin
      w_hold_act_d = 1'b0;
    end else if (r_hold_act && w_held) begin
      if (!r_hold_rep) begin
        if (32'(r_hold_cnt) + 32'd1 >= HOLD_CYCLES) begin
          w_rpt_up     = ~r_hold_dn;
          w_rpt_dn     = r_hold_dn;
          w_hold_rep_d = 1'b1;
          w_rep_cnt_d  = '0;
        end else begin
          w_hold_cnt_d = r_hold_cnt + HoldW'(1);
        end
      end else begin
        if (32'(r_rep_cnt) + 32'd1 >= REPEAT_CYCLES) begin
          w_rpt_up    = ~r_hold_dn;
          w_rpt_dn    = r_hold_dn;
          w_rep_cnt_d = '0;
        end else begin
          w_rep_cnt_d = r_rep_cnt + RepW'(1);
        end
      end
    end else begin
      w_hold_act_d = 1'b0;
    end
  end

  // Hold/repeat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_act <= 1'b0;
      r_hold_dn  <= 1'b0;
      r_hold_rep <= 1'b0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_hold_act <= w_hold_act_d;
      r_hold_dn  <= w_hold_dn_d;
      r_hold_rep <= w_hold_rep_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_rep_cnt  <= w_rep_cnt_d;
    end
  end
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
`endif

  // Field edit: only in SET states, and only when start/mode do not claim the cycle.
  always_comb begin
    w_min_d  = r_min;
    w_hour_d = r_hour;
    if (w_in_set && !w_start_p && !w_mode_p) begin
      if (r_state == StSetMin) begin
        if (w_step_up)      w_min_d = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        else if (w_step_dn) w_min_d = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
      end else begin
        if (w_step_up)      w_hour_d = (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
        else if (w_step_dn) w_hour_d = (r_hour == 6'd0) ? 6'd23 : r_hour - 6'd1;
      end
    end
  end

  // Next state and load strobe; start beats mode, which beats up/down.
  always_comb begin
    w_state_d     = r_state;
    w_rst_state_d = 1'b0;
    case (r_state)
      StSetMin, StSetHour: begin
        if (w_start_p) begin
          if (w_nonzero) begin
            w_state_d     = StRun;
            w_rst_state_d = 1'b1;
          end
        end else if (w_mode_p) begin
          w_state_d = (r_state == StSetMin) ? StSetHour : StSetMin;
        end
      end
      StRun: begin
        // The counter still reads zero during the load cycle, so ignore it then.
        if (io_bus.count_zero && !r_rst_state) begin
          w_state_d = w_mode_p ? StSetMin : StDone;
        end else if (w_start_p) begin
          w_state_d = StPause;
        end else if (w_mode_p) begin
          w_state_d = StSetMin;
        end
      end
      StPause: begin
        if (w_start_p)     w_state_d = StRun;
        else if (w_mode_p) w_state_d = StSetMin;
      end
      StDone: begin
        if (w_start_p) begin
          if (w_nonzero) begin
            w_state_d     = StRun;
            w_rst_state_d = 1'b1;
          end
        end else if (w_mode_p) begin
          w_state_d = StSetMin;
        end
      end
      default: w_state_d = StSetMin;
    endcase
  end

  // State, setting values and load strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StSetMin;
      r_min       <= 6'd0;
      r_hour      <= 6'd0;
      r_rst_state <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_min       <= w_min_d;
      r_hour      <= w_hour_d;
      r_rst_state <= w_rst_state_d;
    end
  end

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] t;
    t = v % 6'd10;
    return t[3:0];
  endfunction

  // The load cycle still looks like editing; run control starts the cycle after.
  assign io_bus.min_ini   = r_min;
  assign io_bus.hour_ini  = r_hour;
  assign io_bus.rst_state = r_rst_state;
  assign io_bus.en        = (r_state == StRun) && !r_rst_state;
  assign io_bus.setting   = w_in_set || r_rst_state;
  assign io_bus.field_sel = (r_state == StSetHour);
  assign io_bus.set_min0  = bcd_ones(r_min);
  assign io_bus.set_min1  = bcd_tens(r_min);
  assign io_bus.set_hour0 = bcd_ones(r_hour);
  assign io_bus.set_hour1 = bcd_tens(r_hour);

endmodule

// File: tb/tb_timer_setter.sv
// tb_timer_setter: directed tests for timer_setter (HOLD_CYCLES=4, REPEAT_CYCLES=2).
module tb_timer_setter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  timer_setter_if u_if ();

  timer_setter #(
    .HOLD_CYCLES  (4),
    .REPEAT_CYCLES(2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0 mode, 1 up, 2 down, 3 start
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: u_if.btn_mode  = v;
      1: u_if.btn_up    = v;
      2: u_if.btn_down  = v;
      default: u_if.btn_start = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick(1);
    set_btn(which, 1'b0);
    tick(1);
  endtask

  task automatic apply_reset();
    u_if.btn_mode = 0; u_if.btn_up = 0; u_if.btn_down = 0; u_if.btn_start = 0;
    u_if.count_zero = 0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    u_if.btn_mode = 0; u_if.btn_up = 0; u_if.btn_down = 0; u_if.btn_start = 0;
    u_if.count_zero = 0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({u_if.min_ini, u_if.hour_ini} !== 12'd0) begin
      n_fail++; $display("FAIL reset_values: got %0d/%0d, want 0/0", u_if.min_ini, u_if.hour_ini);
    end
    n_checks++;
    if ({u_if.rst_state, u_if.en, u_if.setting, u_if.field_sel} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rst_state/en/setting/field_sel=%b, want 0010",
               {u_if.rst_state, u_if.en, u_if.setting, u_if.field_sel});
    end
    n_checks++;
    if ({u_if.set_min1, u_if.set_min0, u_if.set_hour1, u_if.set_hour0} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_digits: got %h, want 0000",
               {u_if.set_min1, u_if.set_min0, u_if.set_hour1, u_if.set_hour0});
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic_edit();
    apply_reset();
    repeat (3) press(1);
    press(0);
    repeat (2) press(1);
    n_checks++;
    if (u_if.min_ini !== 6'd3) begin
      n_fail++; $display("FAIL edit_min: got %0d, want 3", u_if.min_ini);
    end
    n_checks++;
    if (u_if.hour_ini !== 6'd2) begin
      n_fail++; $display("FAIL edit_hour: got %0d, want 2", u_if.hour_ini);
    end
    n_checks++;
    if ({u_if.set_min1, u_if.set_min0, u_if.set_hour1, u_if.set_hour0} !== 16'h0302) begin
      n_fail++;
      $display("FAIL edit_digits: got %h, want 0302",
               {u_if.set_min1, u_if.set_min0, u_if.set_hour1, u_if.set_hour0});
    end
    n_checks++;
    if ({u_if.setting, u_if.en, u_if.field_sel} !== 3'b101) begin
      n_fail++;
      $display("FAIL edit_ctrl: got setting/en/field_sel=%b, want 101",
               {u_if.setting, u_if.en, u_if.field_sel});
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    press(2);
    n_checks++;
    if (u_if.min_ini !== 6'd59 || u_if.set_min1 !== 4'd5 || u_if.set_min0 !== 4'd9) begin
      n_fail++; $display("FAIL wrap_min_down: got %0d (%0d%0d), want 59 (59)",
                         u_if.min_ini, u_if.set_min1, u_if.set_min0);
    end
    press(0);
    press(2);
    n_checks++;
    if (u_if.hour_ini !== 6'd23 || u_if.set_hour1 !== 4'd2 || u_if.set_hour0 !== 4'd3) begin
      n_fail++; $display("FAIL wrap_hour_down: got %0d, want 23", u_if.hour_ini);
    end
    press(1);
    n_checks++;
    if (u_if.hour_ini !== 6'd0) begin
      n_fail++; $display("FAIL wrap_hour_up: got %0d, want 0", u_if.hour_ini);
    end
    n_checks++;
    if (u_if.min_ini !== 6'd59) begin
      n_fail++; $display("FAIL wrap_min_kept: got %0d, want 59", u_if.min_ini);
    end
  endtask

  task automatic test_start_zero();
    apply_reset();
    u_if.btn_start = 1'b1;
    tick(1);
    n_checks++;
    if ({u_if.rst_state, u_if.en, u_if.setting, u_if.field_sel} !== 4'b0010) begin
      n_fail++; $display("FAIL start_zero_ignored: got %b, want 0010",
                         {u_if.rst_state, u_if.en, u_if.setting, u_if.field_sel});
    end
    u_if.btn_start = 1'b0;
    tick(1);
    press(1);
    n_checks++;
    if (u_if.min_ini !== 6'd1) begin
      n_fail++; $display("FAIL start_zero_still_set: got min %0d, want 1", u_if.min_ini);
    end
    u_if.btn_start = 1'b1;
    tick(1);
    n_checks++;
    if ({u_if.rst_state, u_if.en} !== 2'b10) begin
      n_fail++; $display("FAIL start_strobe: got rst_state/en=%b, want 10",
                         {u_if.rst_state, u_if.en});
    end
    tick(1);
    n_checks++;
    if ({u_if.rst_state, u_if.en, u_if.setting} !== 3'b010) begin
      n_fail++; $display("FAIL start_run: got rst_state/en/setting=%b, want 010",
                         {u_if.rst_state, u_if.en, u_if.setting});
    end
    u_if.btn_start = 1'b0;
    tick(1);
  endtask

  // Continues from RUN with min_ini=1.
  task automatic test_pause_done();
    press(1);
    n_checks++;
    if (u_if.min_ini !== 6'd1) begin
      n_fail++; $display("FAIL run_up_ignored: got %0d, want 1", u_if.min_ini);
    end
    press(3);
    n_checks++;
    if ({u_if.en, u_if.setting} !== 2'b00) begin
      n_fail++; $display("FAIL pause: got en/setting=%b, want 00", {u_if.en, u_if.setting});
    end
    u_if.btn_start = 1'b1;
    tick(1);
    n_checks++;
    if ({u_if.rst_state, u_if.en} !== 2'b01) begin
      n_fail++; $display("FAIL resume_no_reload: got rst_state/en=%b, want 01",
                         {u_if.rst_state, u_if.en});
    end
    u_if.btn_start = 1'b0;
    tick(1);
    u_if.count_zero = 1'b1;
    tick(1);
    u_if.count_zero = 1'b0;
    n_checks++;
    if ({u_if.en, u_if.setting} !== 2'b00) begin
      n_fail++; $display("FAIL done: got en/setting=%b, want 00", {u_if.en, u_if.setting});
    end
    u_if.btn_start = 1'b1;
    tick(1);
    n_checks++;
    if (u_if.rst_state !== 1'b1) begin
      n_fail++; $display("FAIL done_reload: got rst_state=%b, want 1", u_if.rst_state);
    end
    u_if.btn_start = 1'b0;
    tick(1);
    n_checks++;
    if ({u_if.rst_state, u_if.en} !== 2'b01) begin
      n_fail++; $display("FAIL done_rerun: got rst_state/en=%b, want 01",
                         {u_if.rst_state, u_if.en});
    end
    // mode wins over count_zero
    u_if.count_zero = 1'b1;
    u_if.btn_mode = 1'b1;
    tick(1);
    u_if.count_zero = 1'b0;
    u_if.btn_mode = 1'b0;
    n_checks++;
    if ({u_if.setting, u_if.en, u_if.field_sel} !== 3'b100) begin
      n_fail++; $display("FAIL mode_over_zero: got setting/en/field_sel=%b, want 100",
                         {u_if.setting, u_if.en, u_if.field_sel});
    end
    n_checks++;
    if (u_if.min_ini !== 6'd1) begin
      n_fail++; $display("FAIL min_retained: got %0d, want 1", u_if.min_ini);
    end
    tick(1);
  endtask

  task automatic test_priority();
    apply_reset();
    press(1);
    u_if.btn_start = 1'b1;
    u_if.btn_mode  = 1'b1;
    tick(1);
    n_checks++;
    if (u_if.rst_state !== 1'b1) begin
      n_fail++; $display("FAIL start_mode_load: got rst_state=%b, want 1", u_if.rst_state);
    end
    u_if.btn_start = 1'b0;
    u_if.btn_mode  = 1'b0;
    tick(1);
    n_checks++;
    if ({u_if.en, u_if.setting, u_if.field_sel} !== 3'b100) begin
      n_fail++; $display("FAIL start_mode_run: got en/setting/field_sel=%b, want 100",
                         {u_if.en, u_if.setting, u_if.field_sel});
    end
    press(0);
    u_if.btn_up   = 1'b1;
    u_if.btn_down = 1'b1;
    tick(1);
    u_if.btn_up   = 1'b0;
    u_if.btn_down = 1'b0;
    tick(1);
    n_checks++;
    if (u_if.min_ini !== 6'd1 || u_if.setting !== 1'b1) begin
      n_fail++; $display("FAIL up_down_cancel: got min %0d setting %b, want 1 1",
                         u_if.min_ini, u_if.setting);
    end
  endtask

  task automatic test_held_reset();
    rst_n = 1'b0;
    u_if.btn_up = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    u_if.btn_up = 1'b0;
    tick(1);
    n_checks++;
    if (u_if.min_ini !== 6'd0) begin
      n_fail++; $display("FAIL held_through_reset: got %0d, want 0", u_if.min_ini);
    end
  endtask

  task automatic test_midrun_reset();
    apply_reset();
    press(1);
    u_if.btn_start = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({u_if.rst_state, u_if.en, u_if.setting, u_if.min_ini} !== {3'b001, 6'd0}) begin
      n_fail++; $display("FAIL midrun_reset: got rst_state/en/setting=%b min %0d, want 001 0",
                         {u_if.rst_state, u_if.en, u_if.setting}, u_if.min_ini);
    end
    u_if.btn_start = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_autorepeat();
    logic [5:0] exp_min;
`ifdef TIMER_SETTER_AUTOREPEAT_EN
    exp_min = 6'd5;
`else
    exp_min = 6'd1;
`endif
    apply_reset();
    u_if.btn_up = 1'b1;
    tick(10);
    u_if.btn_up = 1'b0;
    tick(2);
    n_checks++;
    if (u_if.min_ini !== exp_min) begin
      n_fail++; $display("FAIL autorepeat: got %0d, want %0d", u_if.min_ini, exp_min);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    u_if.btn_mode = 0; u_if.btn_up = 0; u_if.btn_down = 0; u_if.btn_start = 0;
    u_if.count_zero = 0;
    #3;
    test_reset();
    test_basic_edit();
    test_wrap();
    test_start_zero();
    test_pause_done();
    test_priority();
    test_held_reset();
    test_midrun_reset();
    test_autorepeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
